// File: rtl/gate_pattern_gen_if.sv
// Handshake and pattern bus between the pattern generator and the checker that drives it.
// The master side issues start/stop/run_len; the slave side produces the gate inputs and status.
interface gate_pattern_gen_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] run_len;
  logic             a;
  logic             b;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output start, stop, run_len,
    input  a, b, valid, busy, done, cycle_cnt
  );

  modport slave (
    input  start, stop, run_len,
    output a, b, valid, busy, done, cycle_cnt
  );
endinterface

// File: rtl/gate_pattern_gen.sv
// Clocked stimulus source for two-input gate blocks: toggles a and b with independent
// periods for a programmable number of cycles, then pulses done for one cycle.
module gate_pattern_gen #(
  parameter int A_PERIOD = 2,
  parameter int B_PERIOD = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  gate_pattern_gen_if.slave   bus
);

  localparam int A_W = $clog2(A_PERIOD) + 1;
  localparam int B_W = $clog2(B_PERIOD) + 1;
  localparam logic [A_W-1:0] A_LAST = A_W'(A_PERIOD - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(B_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_a;
  logic             r_b;
  logic             w_a;
  logic             w_b;
  logic [A_W-1:0]   r_a_cnt;
  logic [A_W-1:0]   w_a_cnt;
  logic [B_W-1:0]   r_b_cnt;
  logic [B_W-1:0]   w_b_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic [CNT_W-1:0] r_run_len;
  logic [CNT_W-1:0] w_run_len;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  // Next-state and next-pattern logic; the ending edge of a run holds a/b/cycle_cnt
  // so DONE shows the last sample, and leaving DONE clears them for IDLE.
  always_comb begin
    w_next_state = r_state;
    w_a          = r_a;
    w_b          = r_b;
    w_a_cnt      = r_a_cnt;
    w_b_cnt      = r_b_cnt;
    w_cycle_cnt  = r_cycle_cnt;
    w_run_len    = r_run_len;
    case (r_state)
      S_IDLE: begin
        w_a         = 1'b0;
        w_b         = 1'b0;
        w_a_cnt     = '0;
        w_b_cnt     = '0;
        w_cycle_cnt = '0;
        if (bus.start) begin
          w_run_len    = bus.run_len;
          w_next_state = (bus.run_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop || (r_cycle_cnt == r_run_len - CNT_W'(1))) begin
          w_next_state = S_DONE;
        end else begin
          w_cycle_cnt = r_cycle_cnt + CNT_W'(1);
          if (r_a_cnt == A_LAST) begin
            w_a     = ~r_a;
            w_a_cnt = '0;
          end else begin
            w_a_cnt = r_a_cnt + A_W'(1);
          end
          if (r_b_cnt == B_LAST) begin
            w_b     = ~r_b;
            w_b_cnt = '0;
          end else begin
            w_b_cnt = r_b_cnt + B_W'(1);
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_a          = 1'b0;
        w_b          = 1'b0;
        w_a_cnt      = '0;
        w_b_cnt      = '0;
        w_cycle_cnt  = '0;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_a_cnt     <= '0;
      r_b_cnt     <= '0;
      r_cycle_cnt <= '0;
      r_run_len   <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_a         <= w_a;
      r_b         <= w_b;
      r_a_cnt     <= w_a_cnt;
      r_b_cnt     <= w_b_cnt;
      r_cycle_cnt <= w_cycle_cnt;
      r_run_len   <= w_run_len;
      r_valid     <= (w_next_state == S_RUN);
      r_busy      <= (w_next_state != S_IDLE);
      r_done      <= (w_next_state == S_DONE);
    end
  end

  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_gate_pattern_gen.sv
// Bench for gate_pattern_gen: a sample-index model predicts every output each cycle,
// while directed scenarios pin the model with hand-computed sequences.
module tb_gate_pattern_gen;

  localparam int AP = 2;
  localparam int BP = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gate_pattern_gen_if #(.CNT_W(CW)) bus ();

  gate_pattern_gen #(
    .A_PERIOD(AP),
    .B_PERIOD(BP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: mK is the current sample index (-1 when no sample is on the outputs),
  // mDone marks the completion cycle and mLastK the sample it repeats.
  int mK     = -1;
  int mLen   = 0;
  int mLastK = -1;
  bit mDone  = 1'b0;

  int eK;
  int doneCount;
  int validCount;
  int lastDoneCnt;
  int aQ[$];
  int bQ[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mK     = -1;
      mDone  = 1'b0;
      mLastK = -1;
    end else if (mDone) begin
      mDone  = 1'b0;
      mLastK = -1;
    end else if (mK >= 0) begin
      if (bus.stop || mK == mLen - 1) begin
        mLastK = mK;
        mK     = -1;
        mDone  = 1'b1;
      end else begin
        mK++;
      end
    end else if (bus.start) begin
      if (bus.run_len == 0) begin
        mDone  = 1'b1;
        mLastK = -1;
      end else begin
        mLen = int'(bus.run_len);
        mK   = 0;
      end
    end
  end

  // Every-cycle comparison against the model, plus recording for the directed checks.
  always @(negedge clk) begin
    if (mK >= 0)                      eK = mK;
    else if (mDone && mLastK >= 0)    eK = mLastK;
    else                              eK = -1;
    checkOutput("valid", int'(bus.valid), (mK >= 0) ? 1 : 0);
    checkOutput("busy",  int'(bus.busy),  (mK >= 0 || mDone) ? 1 : 0);
    checkOutput("done",  int'(bus.done),  mDone ? 1 : 0);
    checkOutput("a",     int'(bus.a),     (eK >= 0) ? (eK / AP) % 2 : 0);
    checkOutput("b",     int'(bus.b),     (eK >= 0) ? (eK / BP) % 2 : 0);
    checkOutput("cycle_cnt", int'(bus.cycle_cnt), (eK >= 0) ? eK : 0);
    if (bus.valid === 1'b1) begin
      validCount++;
      aQ.push_back(int'(bus.a));
      bQ.push_back(int'(bus.b));
    end
    if (bus.done === 1'b1) begin
      doneCount++;
      lastDoneCnt = int'(bus.cycle_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input int len);
    bus.start   = st;
    bus.stop    = sp;
    bus.run_len = CW'(len);
  endtask

  task automatic clearRecords();
    doneCount   = 0;
    validCount  = 0;
    lastDoneCnt = -1;
    aQ.delete();
    bQ.delete();
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (doneCount == 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_within_budget", (doneCount > 0) ? 1 : 0, 1);
    tick();
  endtask

  task automatic waitSample(input int idx, input int budget);
    int n;
    n = 0;
    while (!(bus.valid === 1'b1 && int'(bus.cycle_cnt) == idx) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("sample_reached", (n < budget) ? 1 : 0, 1);
  endtask

  initial begin
    int expA2[6] = '{0, 0, 1, 1, 0, 0};
    int expB2[6] = '{0, 0, 0, 1, 1, 1};
    int expY2[6] = '{1, 1, 0, 0, 0, 0};
    int expV5[7] = '{1, 1, 1, 0, 0, 1, 1};
    int expD5[7] = '{0, 0, 0, 1, 0, 0, 0};
    int len;

    clearRecords();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 5);

    // Reset held with start high keeps everything at zero.
    repeat (3) begin
      tick();
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_a_b_valid", int'({bus.a, bus.b, bus.valid, bus.done}), 0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 0);
    tick();
    checkOutput("idle_after_rst", int'(bus.busy), 0);

    // Default periods, six samples.
    clearRecords();
    applyStimulus(1'b1, 1'b0, 6);
    tick();
    applyStimulus(1'b0, 1'b0, 6);
    waitDone(20);
    checkOutput("t2_valid_count", validCount, 6);
    checkOutput("t2_done_count", doneCount, 1);
    for (int i = 0; i < 6 && i < aQ.size(); i++) begin
      checkOutput($sformatf("t2_a[%0d]", i), aQ[i], expA2[i]);
      checkOutput($sformatf("t2_b[%0d]", i), bQ[i], expB2[i]);
      checkOutput($sformatf("t2_nor[%0d]", i), (aQ[i] | bQ[i]) ? 0 : 1, expY2[i]);
    end

    // Zero-length run goes straight to a single done.
    clearRecords();
    applyStimulus(1'b1, 1'b0, 0);
    tick();
    checkOutput("t3_done", int'(bus.done), 1);
    checkOutput("t3_valid", int'(bus.valid), 0);
    applyStimulus(1'b0, 1'b0, 0);
    tick();
    checkOutput("t3_done_gone", int'(bus.done), 0);
    checkOutput("t3_busy_gone", int'(bus.busy), 0);
    checkOutput("t3_valid_count", validCount, 0);

    // Stop on sample 4 of a 20-sample run.
    clearRecords();
    applyStimulus(1'b1, 1'b0, 20);
    tick();
    applyStimulus(1'b0, 1'b0, 20);
    waitSample(4, 30);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checkOutput("t4_done", int'(bus.done), 1);
    checkOutput("t4_cnt_in_done", int'(bus.cycle_cnt), 4);
    tick();
    checkOutput("t4_valid_count", validCount, 5);
    checkOutput("t4_done_count", doneCount, 1);
    checkOutput("t4_idle", int'(bus.busy), 0);

    // Start held high: ignored in RUN/DONE, then retriggers from IDLE.
    clearRecords();
    applyStimulus(1'b1, 1'b0, 3);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("t5_valid[%0d]", i), int'(bus.valid), expV5[i]);
      checkOutput($sformatf("t5_done[%0d]", i), int'(bus.done), expD5[i]);
    end
    applyStimulus(1'b0, 1'b0, 3);
    doneCount = 0;
    waitDone(10);

    // Reset in the middle of a 10-sample run.
    clearRecords();
    applyStimulus(1'b1, 1'b0, 10);
    tick();
    applyStimulus(1'b0, 1'b0, 10);
    waitSample(2, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_all_zero", int'({bus.a, bus.b, bus.valid, bus.busy, bus.done}), 0);
    checkOutput("t6_cnt_zero", int'(bus.cycle_cnt), 0);
    repeat (3) tick();
    checkOutput("t6_no_done", doneCount, 0);

    // Random runs with stray start/stop/run_len activity and occasional resets.
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(0, 12);
      applyStimulus(1'b1, 1'b0, len);
      tick();
      for (int c = 0; c < len + 4; c++) begin
        bus.start   = ($urandom_range(0, 3) == 0);
        bus.stop    = ($urandom_range(0, 9) == 0);
        bus.run_len = CW'($urandom_range(0, 255));
        rst         = ($urandom_range(0, 59) == 0);
        tick();
      end
      applyStimulus(1'b0, 1'b0, 0);
      rst = 1'b0;
      repeat (15) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
